fft_mag_buffer: RTL

- Downstream consumer of the oscilloscope FFT core output stream (fft_data / fft_data_valid).
- Per bin: converts complex output to approximate magnitude; stores one 256-bin frame in an internal buffer; tracks peak bin.
- Exposes a registered random-access read port for the display/UI path.
- Sits between FFT core and spectrum display logic, in the FFT clock domain.

---
 rtl/osc_fft_pkg.sv | 23 ++
 rtl/fft_mag_buffer_if.sv | 12 +
 rtl/fft_mag_approx.sv | 63 ++++++
 rtl/fft_mag_buffer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/osc_fft_pkg.sv
// Shared constants, in_data field layout and state encoding for the FFT magnitude buffer.
package osc_fft_pkg;

  localparam int unsigned N_POINTS = 256;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned MAG_W    = 16;
  localparam int unsigned RE_LSB   = 0;
  localparam int unsigned IM_LSB   = 16;
  localparam int unsigned COMP_W   = 16;
  localparam int unsigned DATA_W   = 2 * COMP_W;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } state_e;

  // Two's complement magnitude; -2^(COMP_W-1) maps to 2^(COMP_W-1) as an unsigned value.
  function automatic logic [COMP_W-1:0] abs_comp(input logic [COMP_W-1:0] x);
    return x[COMP_W-1] ? (~x + COMP_W'(1)) : x;
  endfunction

endpackage

// File: rtl/fft_mag_buffer_if.sv
// FFT output stream into the magnitude buffer.
interface fft_mag_buffer_if;
  import osc_fft_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last);
  modport slave  (input in_valid, input in_data, input in_last);

endinterface

// File: rtl/fft_mag_approx.sv
// Two-stage |re|,|im| -> max + min/2 magnitude approximation with valid/last/index sideband.
module fft_mag_approx
  import osc_fft_pkg::*;
(
  input  logic              fft_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] in_idx,
  output logic              out_valid,
  output logic [MAG_W-1:0]  out_mag,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_idx
);

  localparam int unsigned SUM_W = COMP_W + 1;
  localparam logic [MAG_W-1:0] MagMax = '1;

  logic              s1_valid;
  logic [COMP_W-1:0] s1_a;
  logic [COMP_W-1:0] s1_b;
  logic              s1_last;
  logic [ADDR_W-1:0] s1_idx;

  logic [COMP_W-1:0] mx;
  logic [COMP_W-1:0] mn;
  logic [SUM_W-1:0]  sum;
  logic [MAG_W-1:0]  mag;

  always_comb begin
    mx  = (s1_a >= s1_b) ? s1_a : s1_b;
    mn  = (s1_a >= s1_b) ? s1_b : s1_a;
    sum = {1'b0, mx} + {2'b00, mn[COMP_W-1:1]};
    mag = (sum > SUM_W'(MagMax)) ? MagMax : MAG_W'(sum);
  end

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_last   <= 1'b0;
      s1_idx    <= '0;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      s1_valid  <= in_valid & ~flush;
      s1_a      <= abs_comp(in_data[RE_LSB +: COMP_W]);
      s1_b      <= abs_comp(in_data[IM_LSB +: COMP_W]);
      s1_last   <= in_last;
      s1_idx    <= in_idx;
      out_valid <= s1_valid & ~flush;
      out_mag   <= mag;
      out_last  <= s1_last;
      out_idx   <= s1_idx;
    end
  end

endmodule

// File: rtl/fft_mag_buffer.sv
// Captures one FFT frame as approximate magnitudes, tracks the peak bin, serves a registered
// read port to the display path.
module fft_mag_buffer
  import osc_fft_pkg::*;
#(
  parameter bit SKIP_DC = 1'b1
) (
  input  logic                    fft_clk,
  input  logic                    rst_n,
  input  logic                    capture_en,
  input  logic                    rearm,
  fft_mag_buffer_if.slave         in_stream,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [MAG_W-1:0]        rd_data,
  output logic                    frame_done,
  output logic                    frame_ready,
  output logic                    busy,
  output logic [ADDR_W-1:0]       peak_bin,
  output logic [MAG_W-1:0]        peak_mag,
  output logic                    short_frame
);

  localparam logic [ADDR_W-1:0] LastBin = ADDR_W'(N_POINTS - 1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] bin_q;
  logic              in_done_q;
  logic              accept, start_cap, rearm_hit, flush;

  logic              p_valid, p_last;
  logic [MAG_W-1:0]  p_mag;
  logic [ADDR_W-1:0] p_idx;

  logic              wr_valid_q, wr_last_q, wr_en, final_wr;
  logic [MAG_W-1:0]  wr_mag_q;
  logic [ADDR_W-1:0] wr_idx_q;

  logic [MAG_W-1:0]  run_mag_q, cand_mag, peak_mag_q;
  logic [ADDR_W-1:0] run_bin_q, cand_bin, peak_bin_q;
  logic              cand_ok, frame_done_q, short_q;

  logic [MAG_W-1:0]  mem [N_POINTS];

  assign rearm_hit = (state_q == StDone) && rearm && capture_en;
  assign start_cap = ((state_q == StIdle) && capture_en) || rearm_hit;
  assign accept    = (state_q == StCapture) && capture_en && in_stream.in_valid && !in_done_q;
  // Anything still in flight when leaving CAPTURE belongs to a finished or aborted frame.
  assign flush     = (state_q != StCapture);
  assign wr_en     = wr_valid_q && (state_q == StCapture) && capture_en;
  assign final_wr  = wr_en && (wr_last_q || (wr_idx_q == LastBin));

  assign cand_ok  = wr_en && (wr_mag_q > run_mag_q) && !(SKIP_DC && (wr_idx_q == '0));
  assign cand_mag = cand_ok ? wr_mag_q : run_mag_q;
  assign cand_bin = cand_ok ? wr_idx_q : run_bin_q;

  fft_mag_approx u_mag (
    .fft_clk   (fft_clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (accept),
    .in_data   (in_stream.in_data),
    .in_last   (in_stream.in_last),
    .in_idx    (bin_q),
    .out_valid (p_valid),
    .out_mag   (p_mag),
    .out_last  (p_last),
    .out_idx   (p_idx)
  );

  always_comb begin
    state_d = state_q;
    if (!capture_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StCapture;
        StCapture: if (final_wr) state_d = StDone;
        StDone:    if (rearm) state_d = StCapture;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bin_q        <= '0;
      in_done_q    <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_mag_q     <= '0;
      wr_last_q    <= 1'b0;
      wr_idx_q     <= '0;
      run_mag_q    <= '0;
      run_bin_q    <= '0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      frame_done_q <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= final_wr;
      wr_valid_q   <= p_valid & ~flush;
      wr_mag_q     <= p_mag;
      wr_last_q    <= p_last;
      wr_idx_q     <= p_idx;
      if (start_cap || !capture_en) begin
        bin_q     <= '0;
        in_done_q <= 1'b0;
        run_mag_q <= '0;
        run_bin_q <= '0;
      end else begin
        if (accept) begin
          if (bin_q != LastBin) bin_q <= bin_q + 1'b1;
          if (in_stream.in_last || (bin_q == LastBin)) in_done_q <= 1'b1;
        end
        if (wr_en) begin
          run_mag_q <= cand_mag;
          run_bin_q <= cand_bin;
        end
      end
      if (final_wr) begin
        peak_mag_q <= cand_mag;
        peak_bin_q <= cand_bin;
        if (wr_idx_q != LastBin) short_q <= 1'b1;
      end else if (rearm_hit) begin
        short_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge fft_clk) begin
    if (wr_en) mem[wr_idx_q] <= wr_mag_q;
  end

  // Read-before-write: a same-cycle write to rd_addr is seen on the following read.
  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

  assign busy        = (state_q == StCapture);
  assign frame_ready = (state_q == StDone);
  assign frame_done  = frame_done_q;
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;
  assign short_frame = short_q;

endmodule
